// File: rtl/pong_game_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : pong_game_ctrl
// Description : Two-player pong controller covering the motion tick, the
//               serve/play/score state machine, and ball and paddle positions.
// Revision    : 1.0 - initial release
// ============================================================================
module pong_game_ctrl #(
    parameter int TICK_DIV   = 500000,
    parameter int SERVE_WAIT = 60,
    parameter int WIN_SCORE  = 7
) (
    input  logic       clk50M,
    input  logic       rst,
    input  logic       start,
    input  logic       p1_up,
    input  logic       p1_down,
    input  logic       p2_up,
    input  logic       p2_down,
    output logic [9:0] ball_x,
    output logic [9:0] ball_y,
    output logic [9:0] paddle_one_x,
    output logic [9:0] paddle_one_y,
    output logic [9:0] paddle_two_x,
    output logic [9:0] paddle_two_y,
    output logic [3:0] score_one,
    output logic [3:0] score_two,
    output logic [2:0] state,
    output logic       game_over,
    output logic       winner,
    output logic       tick
);

    localparam int c_cnt_w = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam int c_srv_w = (SERVE_WAIT > 1) ? $clog2(SERVE_WAIT + 1) : 1;

    localparam logic [c_cnt_w-1:0] c_tick_last  = c_cnt_w'(TICK_DIV - 1);
    localparam logic [c_srv_w-1:0] c_serve_wait = c_srv_w'(SERVE_WAIT);
    localparam logic [3:0]         c_win        = 4'(WIN_SCORE);

    localparam logic [9:0] c_ball_x0    = 10'd316;
    localparam logic [9:0] c_ball_y0    = 10'd236;
    localparam logic [9:0] c_ball_x_max = 10'd632;
    localparam logic [9:0] c_ball_y_max = 10'd472;
    localparam logic [9:0] c_hit_one_x  = 10'd24;
    localparam logic [9:0] c_hit_two_x  = 10'd608;
    localparam logic [9:0] c_pad_y0     = 10'd208;
    localparam logic [9:0] c_pad_y_max  = 10'd416;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SERVE = 3'd1,
        ST_PLAY  = 3'd2,
        ST_POINT = 3'd3,
        ST_OVER  = 3'd4
    } state_t;

    state_t               state_q, state_d;
    logic [c_cnt_w-1:0]   tick_cnt_q, tick_cnt_d;
    logic [c_srv_w-1:0]   serve_cnt_q, serve_cnt_d;
    logic [9:0]           ball_x_q, ball_x_d;
    logic [9:0]           ball_y_q, ball_y_d;
    logic                 dx_q, dx_d;           // 1 = moving right
    logic                 dy_q, dy_d;           // 1 = moving down
    logic [9:0]           p1_y_q, p1_y_d;
    logic [9:0]           p2_y_q, p2_y_d;
    logic [3:0]           score_one_q, score_one_d;
    logic [3:0]           score_two_q, score_two_d;
    logic                 point_two_q, point_two_d;
    logic                 winner_q, winner_d;
    logic                 game_over_q, game_over_d;

    logic                 w_tick;
    logic [c_srv_w-1:0]   w_serve_next;
    logic [3:0]           w_score_next;

    function automatic logic [9:0] paddle_step(input logic [9:0] y,
                                               input logic up,
                                               input logic dn);
        logic [9:0] r;
        r = y;
        if (up && !dn) begin
            r = (y < 10'd2) ? 10'd0 : y - 10'd2;
        end else if (dn && !up) begin
            r = (y > c_pad_y_max - 10'd2) ? c_pad_y_max : y + 10'd2;
        end
        return r;
    endfunction

    function automatic logic overlap(input logic [9:0] by, input logic [9:0] py);
        return (({1'b0, by} + 11'd8) > {1'b0, py}) && ({1'b0, by} < ({1'b0, py} + 11'd64));
    endfunction

    assign w_tick       = (tick_cnt_q == c_tick_last);
    assign w_serve_next = serve_cnt_q + c_srv_w'(1);
    assign w_score_next = point_two_q ? (score_two_q + 4'd1) : (score_one_q + 4'd1);

    always_comb begin
        state_d     = state_q;
        tick_cnt_d  = w_tick ? '0 : tick_cnt_q + c_cnt_w'(1);
        serve_cnt_d = serve_cnt_q;
        ball_x_d    = ball_x_q;
        ball_y_d    = ball_y_q;
        dx_d        = dx_q;
        dy_d        = dy_q;
        p1_y_d      = p1_y_q;
        p2_y_d      = p2_y_q;
        score_one_d = score_one_q;
        score_two_d = score_two_q;
        point_two_d = point_two_q;
        winner_d    = winner_q;

        if (w_tick && (state_q == ST_SERVE || state_q == ST_PLAY)) begin
            p1_y_d = paddle_step(p1_y_q, p1_up, p1_down);
            p2_y_d = paddle_step(p2_y_q, p2_up, p2_down);
        end

        case (state_q)
            ST_IDLE, ST_OVER: begin
                if (start) begin
                    score_one_d = 4'd0;
                    score_two_d = 4'd0;
                    dx_d        = 1'b1;
                    if (state_q == ST_IDLE) begin
                        dy_d = 1'b1;
                    end
                    ball_x_d    = c_ball_x0;
                    ball_y_d    = c_ball_y0;
                    serve_cnt_d = '0;
                    state_d     = ST_SERVE;
                end
            end
            ST_SERVE: begin
                if (w_tick) begin
                    serve_cnt_d = w_serve_next;
                    if (w_serve_next == c_serve_wait) begin
                        state_d = ST_PLAY;
                    end
                end
            end
            ST_PLAY: begin
                if (w_tick) begin
                    // Horizontal and vertical rules are independent, so a wall and paddle flip can coincide.
                    if (!dx_q) begin
                        if (ball_x_q == 10'd0) begin
                            point_two_d = 1'b1;
                            state_d     = ST_POINT;
                        end else if (ball_x_q == c_hit_one_x && overlap(ball_y_q, p1_y_q)) begin
                            dx_d = 1'b1;
                        end else begin
                            ball_x_d = ball_x_q - 10'd1;
                        end
                    end else begin
                        if (ball_x_q == c_ball_x_max) begin
                            point_two_d = 1'b0;
                            state_d     = ST_POINT;
                        end else if (ball_x_q == c_hit_two_x && overlap(ball_y_q, p2_y_q)) begin
                            dx_d = 1'b0;
                        end else begin
                            ball_x_d = ball_x_q + 10'd1;
                        end
                    end

                    if (!dy_q) begin
                        if (ball_y_q == 10'd0) dy_d = 1'b1;
                        else                   ball_y_d = ball_y_q - 10'd1;
                    end else begin
                        if (ball_y_q == c_ball_y_max) dy_d = 1'b0;
                        else                          ball_y_d = ball_y_q + 10'd1;
                    end
                end
            end
            ST_POINT: begin
                if (point_two_q) score_two_d = w_score_next;
                else             score_one_d = w_score_next;
                if (w_score_next == c_win) begin
                    winner_d = point_two_q;
                    state_d  = ST_OVER;
                end else begin
                    // Next serve heads toward the player who just lost the point.
                    dx_d        = ~point_two_q;
                    ball_x_d    = c_ball_x0;
                    ball_y_d    = c_ball_y0;
                    serve_cnt_d = '0;
                    state_d     = ST_SERVE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        game_over_d = (state_d == ST_OVER);
    end

    always_ff @(posedge clk50M or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            tick_cnt_q  <= '0;
            serve_cnt_q <= '0;
            ball_x_q    <= c_ball_x0;
            ball_y_q    <= c_ball_y0;
            dx_q        <= 1'b1;
            dy_q        <= 1'b1;
            p1_y_q      <= c_pad_y0;
            p2_y_q      <= c_pad_y0;
            score_one_q <= 4'd0;
            score_two_q <= 4'd0;
            point_two_q <= 1'b0;
            winner_q    <= 1'b0;
            game_over_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            tick_cnt_q  <= tick_cnt_d;
            serve_cnt_q <= serve_cnt_d;
            ball_x_q    <= ball_x_d;
            ball_y_q    <= ball_y_d;
            dx_q        <= dx_d;
            dy_q        <= dy_d;
            p1_y_q      <= p1_y_d;
            p2_y_q      <= p2_y_d;
            score_one_q <= score_one_d;
            score_two_q <= score_two_d;
            point_two_q <= point_two_d;
            winner_q    <= winner_d;
            game_over_q <= game_over_d;
        end
    end

    assign ball_x       = ball_x_q;
    assign ball_y       = ball_y_q;
    assign paddle_one_x = 10'd16;
    assign paddle_one_y = p1_y_q;
    assign paddle_two_x = 10'd616;
    assign paddle_two_y = p2_y_q;
    assign score_one    = score_one_q;
    assign score_two    = score_two_q;
    assign state        = state_q;
    assign game_over    = game_over_q;
    assign winner       = winner_q;
    assign tick         = w_tick;

endmodule
`default_nettype wire

// File: doc/pong_game_ctrl.md
PONG_GAME_CTRL -- requirements
Module: pong_game_ctrl

Interface
REQ-001 Parameter TICK_DIV, default 500000: clk50M cycles per motion tick, legal range 2..2^20.
REQ-002 Parameter SERVE_WAIT, default 60: motion ticks the ball is held at center before play.
REQ-003 Parameter WIN_SCORE, default 7: points that end the game, legal range 1..15.
REQ-004 Geometry is fixed: screen 640x480, ball 8x8, paddle 8 wide x 64 high, position step 1 px per tick for the ball and 2 px per tick for the paddles.
REQ-005 clk50M  in  1  sole clock, all state on the rising edge.
REQ-006 rst  in  1  reset, asynchronous, active-high.
REQ-007 start  in  1  level; sampled every clk50M cycle, acted on in IDLE and OVER.
REQ-008 p1_up, p1_down, p2_up, p2_down  in  1 each  paddle controls, sampled on tick.
REQ-009 ball_x, ball_y  out  10 each  ball top-left pixel.
REQ-010 paddle_one_x, paddle_one_y, paddle_two_x, paddle_two_y  out  10 each  paddle top-left pixel.
REQ-011 score_one, score_two  out  4 each  points won.
REQ-012 state  out  3  IDLE=0, SERVE=1, PLAY=2, POINT=3, OVER=4.
REQ-013 game_over  out  1  high only in OVER; winner  out  1  0=player one, 1=player two, valid when game_over=1.
REQ-014 tick  out  1  one-cycle motion-tick strobe.

Function
REQ-015 Tick counter counts 0..TICK_DIV-1 and wraps; tick=1 exactly in the cycle the counter equals TICK_DIV-1; it runs in every state.
REQ-016 paddle_one_x is constant 16 and paddle_two_x is constant 616.
REQ-017 In SERVE and PLAY, on tick: up-only decreases paddle y by 2, down-only increases it by 2, clamped to 0..416; both or neither pressed leaves it unchanged.
REQ-018 IDLE: outputs hold; start=1 clears both scores, sets dx=right and dy=down, and enters SERVE on the next cycle.
REQ-019 SERVE entry: ball at (316,236) and serve counter cleared; on each tick the counter increments, and the tick on which it reaches SERVE_WAIT enters PLAY with the ball still at center.
REQ-020 PLAY, on tick: x and y advance 1 px by direction unless a boundary rule below applies; x and y are evaluated independently in the same tick.
REQ-021 Top/bottom: when moving up with ball_y=0, or down with ball_y=472, flip dy and hold y that tick.
REQ-022 Left paddle: when moving left with ball_x=24 and vertical overlap (ball_y+8 > paddle_one_y and ball_y < paddle_one_y+64), set dx=right and hold x.
REQ-023 Right paddle: when moving right with ball_x=608 and overlap with paddle two by the same rule, set dx=left and hold x.
REQ-024 Miss: moving left with ball_x=0 latches point-to-two; moving right with ball_x=632 latches point-to-one; either one enters POINT on the next cycle with the ball held.
REQ-025 Without overlap at x=24 or x=608, the ball passes through and continues toward the edge.
REQ-026 POINT lasts exactly one cycle: the latched scorer's score increments; if the new score equals WIN_SCORE, enter OVER with winner set, else enter SERVE with dx pointing toward the player who lost the point and dy unchanged.
REQ-027 OVER: ball, paddles and scores hold; start=1 clears both scores, clears game_over, and enters SERVE with dx=right.
REQ-028 Scores never exceed WIN_SCORE; no other path modifies them.
REQ-029 The corner case where a wall flip and a paddle flip fall on the same tick applies both flips.

Reset
REQ-030 rst=1 immediately forces: state=IDLE, tick counter=0, serve counter=0, ball=(316,236), dx=right, dy=down, paddle_one_y=paddle_two_y=208, scores=0, game_over=0, winner=0, tick=0.
REQ-031 Reset asserted mid-game from any state takes effect at once without waiting for a clock edge; operation resumes from IDLE after release.

Verification (TICK_DIV=4, SERVE_WAIT=2, WIN_SCORE=2)
REQ-032 Reset then start pulse -> state goes IDLE to SERVE, the ball stays at (316,236) for 2 ticks, state=PLAY, and after 1 tick the ball is at (317,237).
REQ-033 Hold p1_up for 110 ticks from y=208 -> paddle_one_y decreases 2 per tick to 0 and stays 0; p1_up and p1_down together produce no movement.
REQ-034 Force a leftward ball at x=24 with y overlapping the paddle -> dx=right, x unchanged that tick, 25 on the next tick; repeat with y outside the paddle -> the ball reaches x=0, POINT lasts 1 cycle, score_two=1, and SERVE is entered with dx=left.
REQ-035 Ball moving up at y=0 -> dy=down, y=0 that tick and 1 on the next.
REQ-036 Player two scores 2 points -> state=OVER, game_over=1, winner=1, outputs frozen; start -> scores 0, state=SERVE.
REQ-037 Assert rst for 1 ns mid-PLAY between clock edges -> all outputs show their REQ-030 values before the next edge.
